ram_rsp: RTL
============

// Module: ram_rsp
// PURPOSE
// - Data-memory responder serving the LSU request port of the multi-cycle core.
// - Accepts one load/store request via valid/ready, performs a byte-masked write or a word read on
//   internal storage, and returns a response after a fixed, parameterised latency.
// - Exactly one request is outstanding at a time. Replaces the zero-latency ram for stall testing.
// PARAMETERS
// - DATA_WIDTH  32            word width in bits; multiple of 8
// - ADDR_WIDTH  32            request byte-address width
// - DEPTH_LOG2  10            log2 of storage depth, in words
// - LAT         2             accept-to-response latency in cycles; legal range 1..15
// - BASE_ADDR   32'h8000_0000 byte address of word 0
// PORTS
// - i_sys_clk        in   1              clock; rising edge
// - i_sys_rst_n      in   1              asynchronous active-low reset
// - i_lsu_req_valid  in   1              request valid
// - o_ram_req_ready  out  1              responder can accept; 1 only in IDLE
// - i_lsu_req_wr     in   1              1 = store, 0 = load
// - i_lsu_req_addr   in   ADDR_WIDTH     byte address
// - i_lsu_req_data   in   DATA_WIDTH     store data
// - i_lsu_req_mask   in   DATA_WIDTH/8   store byte enables; bit i covers byte i
// - o_ram_rsp_valid  out  1              response valid
// - i_lsu_rsp_ready  in   1              requester accepts the response
// - o_ram_rsp_data   out  DATA_WIDTH     load data; 0 for stores
// - o_ram_rsp_err    out  1              error flag; present only with RAM_RSP_ERR_EN
// BEHAVIOUR
// - Reset (async): state=IDLE, cnt=0, o_ram_rsp_valid=0, o_ram_rsp_data=0, o_ram_rsp_err=0.
//   o_ram_req_ready=1 (decoded from IDLE). Storage contents are not reset.
// - Accept: a request is accepted on the edge where i_lsu_req_valid & o_ram_req_ready = 1.
// - Word index: idx = (addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits (modulo wrap).
//   addr[1:0] is ignored, so misaligned addresses act as aligned.
// - Store: on the accept edge, each byte i with mask[i]=1 is written; other bytes are unchanged.
//   A store with mask=0 is a legal no-op and still returns a response.
// - Load: on the accept edge, the word at idx is latched into a read register.
// - FSM
//   - IDLE -> WAIT on accept. cnt loads LAT-1.
//   - WAIT: cnt decrements each cycle. When cnt=0, go to RESP and drive o_ram_rsp_valid=1 with the data.
//   - With LAT=1, go IDLE -> RESP directly; valid is high in the cycle after accept.
//   - RESP: valid and data are held stable until i_lsu_rsp_ready=1. Then go to IDLE; valid drops next cycle.
//   - Total latency: valid rises exactly LAT cycles after the accept edge.
// - Ready never rises in the same cycle as a response handshake (no back-to-back overlap).
//   Minimum request spacing is LAT+1 cycles.
// - i_lsu_rsp_ready outside RESP is ignored. Request inputs outside IDLE are ignored.
// - If reset is asserted mid-operation, the transaction is dropped: no response, and IDLE on release.
//   A store already accepted stays committed.
// CONFIGURATION
// - RAM_RSP_ERR_EN defined: o_ram_rsp_err exists.
//   - An address below BASE_ADDR, or at/above BASE_ADDR + 4*2^DEPTH_LOG2, is out of range.
//   - Out-of-range requests take the same latency and handshake, with err=1, data=0, and no store.
//   - err is valid with o_ram_rsp_valid and is 0 otherwise.
// - RAM_RSP_ERR_EN undefined: no err port; out-of-range addresses wrap modulo depth with no flag.
// TESTING
// - Reset: hold rst_n=0 -> ready=1, rsp_valid=0, rsp_data=0 immediately (async).
// - Store then load, LAT=2: store addr 0x8000_0010, data 0xDEADBEEF, mask 4'b1111.
//   Then store mask 4'b0010, data 0x0000_5500. Load 0x8000_0010 -> 0xDEAD55EF, valid 2 cycles after accept.
// - Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> valid and data stable, ready=0 throughout.
//   Then rsp_ready=1 -> IDLE, ready=1 next cycle.
// - LAT=1: load -> valid in the cycle after accept. Misaligned load 0x8000_0013 -> same word as 0x8000_0010.
// - Abort: assert rst_n=0 while in WAIT -> no response ever appears; first request after release completes normally.
// - Error (RAM_RSP_ERR_EN): store to 0x7FFF_FFFC -> err=1, no write.
//   Load 0x8000_1000 with DEPTH_LOG2=10 -> err=1, data=0. Without the macro, that load returns the word at 0x8000_0000.

Source files
------------

// File: rtl/ram_rsp.sv
// ram_rsp: data-memory responder for the LSU request port; byte-masked stores, word loads.
// Latency: response valid LAT cycles after the accept cycle (LAT=1 -> the cycle right after).
// Backpressure: one request outstanding; ready only in IDLE; response held until i_lsu_rsp_ready.
// Optional feature macro RAM_RSP_ERR_EN: adds o_ram_rsp_err and out-of-range detection.
module ram_rsp #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter int                    LAT        = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst_n,
  input  logic                    i_lsu_req_valid,
  output logic                    o_ram_req_ready,
  input  logic                    i_lsu_req_wr,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_lsu_req_data,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_req_mask,
  output logic                    o_ram_rsp_valid,
  input  logic                    i_lsu_rsp_ready,
`ifdef RAM_RSP_ERR_EN
  output logic                    o_ram_rsp_err,
`endif
  output logic [DATA_WIDTH-1:0]   o_ram_rsp_data
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam int         NBYTES   = DATA_WIDTH / 8;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  // Counter value loaded on accept; RESP is entered on the cycle it steps 1 -> 0.
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_rsp_dat;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_acc;
  logic                  w_oor;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign o_ram_req_ready = (r_state == S_IDLE);
  assign o_ram_rsp_valid = (r_state == S_RESP);
  assign o_ram_rsp_data  = r_rsp_dat;

  assign w_acc = i_lsu_req_valid & o_ram_req_ready;
  // Byte offset from word 0; low two bits dropped so misaligned addresses act aligned,
  // upper bits truncated so the index wraps modulo depth.
  assign w_off = i_lsu_req_addr - BASE_ADDR;
  assign w_idx = w_off[DEPTH_LOG2+1:2];

`ifdef RAM_RSP_ERR_EN
  // Below base, or any offset bit above the storage window set, is out of range.
  assign w_oor         = (i_lsu_req_addr < BASE_ADDR) | (|w_off[ADDR_WIDTH-1:DEPTH_LOG2+2]);
  assign o_ram_rsp_err = r_err & o_ram_rsp_valid;
  logic w_unused;
  assign w_unused = ^w_off[1:0];
`else
  assign w_oor = 1'b0;
  logic w_unused;
  assign w_unused = ^{w_off[1:0], w_off[ADDR_WIDTH-1:DEPTH_LOG2+2], r_err};
`endif

  // Writes are blocked while reset is held, since ready reads 1 during reset.
  assign w_wr_en = w_acc & i_lsu_req_wr & ~w_oor & i_sys_rst_n;

  // Storage: byte-masked write on the accept edge; contents survive reset.
  always_ff @(posedge i_sys_clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (i_lsu_req_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= i_lsu_req_data[8*i +: 8];
        end
      end
    end
  end

  // Control FSM: latch read data/err on accept, count down, hold response until taken.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_rsp_dat <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_err     <= w_oor;
            r_rsp_dat <= (i_lsu_req_wr || w_oor) ? '0 : r_mem[w_idx];
            r_cnt     <= CNT_INIT;
            r_state   <= (LAT == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_lsu_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
